// File: rtl/uart_ctrl_if.sv
// AXI4-Lite bus with 32-bit address and data, as seen by the UART register block.
interface axi_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/uart_ctrl.sv
// AXI-Lite register block, TX FIFO and 8N1 serializer for a transmit-only UART.
// state   | meaning
// W_IDLE / W_GOT_AW / W_GOT_W / W_RESP | waiting, AW held, W held, B pending
// R_IDLE / R_RESP                      | waiting for AR, R pending
// S_IDLE / S_START / S_DATA / S_STOP   | line idle, start bit, data bits, stop bit
module uart_ctrl #(
    parameter logic [31:0]      BASE_ADDR  = 32'ha00003f8,
    parameter int               FIFO_DEPTH = 16,
    parameter int               DIV_W      = 16,
    parameter logic [DIV_W-1:0] DIV_RST    = 16'd868
) (
    input  logic       clk,
    input  logic       reset,
    axi_lite_if.slave  s,
    output logic       tx,
    output logic       irq
);
    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT    = (AW+1)'(FIFO_DEPTH);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  REG_TXDATA  = 2'd0;
    localparam logic [1:0]  REG_STATUS  = 2'd1;
    localparam logic [1:0]  REG_DIV     = 2'd2;
    localparam logic [1:0]  REG_CTRL    = 2'd3;

    typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_RESP} r_state_t;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} s_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    s_state_t s_state, s_next;

    logic [31:0]      aw_addr_q, w_data_q, wr_addr, wr_data, rd_val, rdata_q;
    logic [1:0]       bresp_q, rresp_q, wr_sel;
    logic             wr_commit, wr_err, rd_err, push, pop, fifo_clr;
    logic [DIV_W-1:0] div, div_eff, div_lat, bit_cnt;
    logic             ctrl_tx_en, ctrl_ie, can_start, bit_tc;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             fifo_full, fifo_empty, busy;
    logic [7:0]       shreg;
    logic [2:0]       bit_idx;
    logic             unused_bits;

    // The window is the 16-byte aligned block that holds BASE_ADDR; addr[3:2] picks the register.
    function automatic logic in_window(input logic [31:0] a);
        return a[31:4] == BASE_ADDR[31:4];
    endfunction

    assign s.awready = (w_state == W_IDLE) || (w_state == W_GOT_W);
    assign s.wready  = (w_state == W_IDLE) || (w_state == W_GOT_AW);
    assign s.bvalid  = (w_state == W_RESP);
    assign s.bresp   = bresp_q;
    assign s.arready = (r_state == R_IDLE);
    assign s.rvalid  = (r_state == R_RESP);
    assign s.rdata   = rdata_q;
    assign s.rresp   = rresp_q;

    assign wr_addr     = (w_state == W_GOT_AW) ? aw_addr_q : s.awaddr;
    assign wr_data     = (w_state == W_GOT_W)  ? w_data_q  : s.wdata;
    assign wr_sel      = wr_addr[3:2];
    assign unused_bits = ^{wr_data, wr_addr[1:0], s.araddr[1:0]};

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign busy       = (s_state != S_IDLE);
    assign irq        = ctrl_ie && fifo_empty;

    always_comb begin
        w_next    = w_state;
        wr_commit = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (s.awvalid && s.wvalid) begin
                    wr_commit = 1'b1;
                    w_next    = W_RESP;
                end else if (s.awvalid) begin
                    w_next = W_GOT_AW;
                end else if (s.wvalid) begin
                    w_next = W_GOT_W;
                end
            end
            W_GOT_AW: if (s.wvalid) begin
                wr_commit = 1'b1;
                w_next    = W_RESP;
            end
            W_GOT_W: if (s.awvalid) begin
                wr_commit = 1'b1;
                w_next    = W_RESP;
            end
            default: if (s.bready) w_next = W_IDLE;
        endcase
    end

    // Full is judged on the pre-pop count, so a push racing a pop while full is still refused.
    assign wr_err   = !in_window(wr_addr) || (wr_sel == REG_STATUS) ||
                      ((wr_sel == REG_TXDATA) && fifo_full);
    assign push     = wr_commit && !wr_err && (wr_sel == REG_TXDATA);
    assign fifo_clr = wr_commit && !wr_err && (wr_sel == REG_CTRL) && wr_data[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state    <= W_IDLE;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            bresp_q    <= RESP_OKAY;
            div        <= DIV_RST;
            ctrl_tx_en <= 1'b0;
            ctrl_ie    <= 1'b0;
        end else begin
            w_state <= w_next;
            if (s.awvalid && s.awready) aw_addr_q <= s.awaddr;
            if (s.wvalid && s.wready)   w_data_q  <= s.wdata;
            if (wr_commit) begin
                bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
                if (!wr_err && (wr_sel == REG_DIV)) div <= wr_data[DIV_W-1:0];
                if (!wr_err && (wr_sel == REG_CTRL)) begin
                    ctrl_tx_en <= wr_data[0];
                    ctrl_ie    <= wr_data[1];
                end
            end
        end
    end

    always_comb begin
        rd_err = !in_window(s.araddr);
        rd_val = '0;
        if (!rd_err) begin
            case (s.araddr[3:2])
                REG_STATUS: rd_val = {16'h0, 8'(count), 5'h0, busy, fifo_empty, fifo_full};
                REG_DIV:    rd_val[DIV_W-1:0] = div;
                REG_CTRL:   rd_val = {30'h0, ctrl_ie, ctrl_tx_en};
                default:    rd_val = '0;
            endcase
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (s.arvalid) r_next = R_RESP;
            default: if (s.rready)  r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            r_state <= r_next;
            if (s.arvalid && s.arready) begin
                rdata_q <= rd_val;
                rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (fifo_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign div_eff   = (div == '0) ? DIV_W'(1) : div;
    assign bit_tc    = (bit_cnt == '0);
    assign can_start = ctrl_tx_en && !fifo_empty && !fifo_clr;

    always_comb begin
        s_next = s_state;
        pop    = 1'b0;
        case (s_state)
            S_IDLE: if (can_start) begin
                pop    = 1'b1;
                s_next = S_START;
            end
            S_START: if (bit_tc) s_next = S_DATA;
            S_DATA:  if (bit_tc && (bit_idx == 3'd7)) s_next = S_STOP;
            default: if (bit_tc) begin
                if (can_start) begin
                    pop    = 1'b1;
                    s_next = S_START;
                end else begin
                    s_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_state <= S_IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            bit_cnt <= '0;
            div_lat <= DIV_W'(1);
        end else begin
            s_state <= s_next;
            if (pop) begin
                shreg   <= mem[rd_ptr];
                div_lat <= div_eff;
                bit_cnt <= div_eff - 1'b1;
            end else if (s_state != S_IDLE) begin
                if (bit_tc) begin
                    bit_cnt <= div_lat - 1'b1;
                    if (s_state == S_START) bit_idx <= '0;
                    if (s_state == S_DATA) begin
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end
                end else begin
                    bit_cnt <= bit_cnt - 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (s_state)
            S_START: tx = 1'b0;
            S_DATA:  tx = shreg[0];
            default: tx = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: register vectors, scoreboarded AXI responses, line timing.
module tb_uart_ctrl;
    localparam logic [31:0] A_TXD  = 32'ha00003f0;
    localparam logic [31:0] A_STAT = 32'ha00003f4;
    localparam logic [31:0] A_DIV  = 32'ha00003f8;
    localparam logic [31:0] A_CTRL = 32'ha00003fc;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tx, irq;
    axi_lite_if bus();

    uart_ctrl dut (.clk(clk), .reset(reset), .s(bus), .tx(tx), .irq(irq));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          is_rd;
        logic [1:0]  resp;
        logic [31:0] data;
        string       nm;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;
    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timeout, got no handshake, required one within 20 cycles", name);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.bvalid && bus.bready) begin
            if (sbq.size() == 0 || sbq[0].is_rd) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_b: got bresp %0d, required no write response", bus.bresp);
            end else begin
                e = sbq.pop_front();
                check({e.nm, "_bresp"}, 32'(bus.bresp), 32'(e.resp));
            end
        end
        if (bus.rvalid && bus.rready) begin
            if (sbq.size() == 0 || !sbq[0].is_rd) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_r: got rdata 0x%08h, required no read response", bus.rdata);
            end else begin
                e = sbq.pop_front();
                check({e.nm, "_rresp"}, 32'(bus.rresp), 32'(e.resp));
                check({e.nm, "_rdata"}, bus.rdata, e.data);
            end
        end
    end

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] resp, input string tag);
        int n;
        sbq.push_back('{is_rd: 1'b0, resp: resp, data: 32'h0, nm: tag});
        @(posedge clk); #1;
        bus.awaddr = addr; bus.awvalid = 1'b1;
        bus.wdata = data;  bus.wvalid = 1'b1;
        bus.bready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(bus.awready && bus.wready) && n < 20);
        if (!(bus.awready && bus.wready)) timeout({tag, "_aw"});
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.bvalid && n < 20);
        if (!bus.bvalid) timeout({tag, "_b"});
        @(posedge clk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] resp, input string tag);
        int n;
        sbq.push_back('{is_rd: 1'b1, resp: resp, data: data, nm: tag});
        @(posedge clk); #1;
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.arready && n < 20);
        if (!bus.arready) timeout({tag, "_ar"});
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rvalid && n < 20);
        if (!bus.rvalid) timeout({tag, "_r"});
        @(posedge clk); #1;
        bus.rready = 1'b0;
    endtask

    // Expected line levels, bit 0 first, each held div cycles; then one idle-high cycle.
    task automatic watch_tx(input logic [19:0] pattern, input int nbits, input int div,
                            input string tag);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (tx !== 1'b0 && n < 60);
        if (tx !== 1'b0) begin
            timeout({tag, "_start"});
        end else begin
            for (int i = 0; i < nbits * div; i++) begin
                check($sformatf("%s_c%0d", tag, i), 32'(tx), 32'(pattern[i / div]));
                @(negedge clk);
            end
            check({tag, "_idle"}, 32'(tx), 32'h1);
        end
    endtask

    initial begin
        int n;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        vt.push_back('{1'b0, A_STAT, 32'h0,      OKAY,   32'h00000002});
        vt.push_back('{1'b0, A_DIV,  32'h0,      OKAY,   32'h00000364});
        vt.push_back('{1'b0, A_TXD,  32'h0,      OKAY,   32'h00000000});
        vt.push_back('{1'b0, A_CTRL, 32'h0,      OKAY,   32'h00000000});
        vt.push_back('{1'b1, A_DIV,  32'h4,      OKAY,   32'h0});
        vt.push_back('{1'b0, A_DIV,  32'h0,      OKAY,   32'h00000004});
        vt.push_back('{1'b1, A_CTRL, 32'h6,      OKAY,   32'h0});
        vt.push_back('{1'b0, A_CTRL, 32'h0,      OKAY,   32'h00000002});
        vt.push_back('{1'b0, 32'ha0000400, 32'h0, SLVERR, 32'h00000000});
        vt.push_back('{1'b1, A_STAT, 32'hffff,   SLVERR, 32'h0});
        vt.push_back('{1'b0, A_STAT, 32'h0,      OKAY,   32'h00000002});
        vt.push_back('{1'b1, 32'h00000008, 32'h55, SLVERR, 32'h0});
        vt.push_back('{1'b1, 32'ha0000400, 32'h1234, SLVERR, 32'h0});
        vt.push_back('{1'b0, A_DIV,  32'h0,      OKAY,   32'h00000004});

        // reset values while held in reset: {tx,irq,bvalid,rvalid,awready,arready,wready}
        repeat (3) @(negedge clk);
        check("reset_outs", {25'h0, tx, irq, bus.bvalid, bus.rvalid, bus.awready,
                             bus.arready, bus.wready}, 32'h47);
        reset = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].wr) axi_write(vt[i].addr, vt[i].data, vt[i].resp, $sformatf("vec%0d", i));
            else          axi_read(vt[i].addr, vt[i].rdata, vt[i].resp, $sformatf("vec%0d", i));
        end
        @(negedge clk);
        check("irq_ie_empty", 32'(irq), 32'h1);
        axi_write(A_CTRL, 32'h0, OKAY, "ctrl_off");
        @(negedge clk);
        check("irq_off", 32'(irq), 32'h0);

        // overflow: 16 accepted, 17th refused, FIFO left full
        for (int i = 0; i < 17; i++)
            axi_write(A_TXD, 32'(i), (i < 16) ? OKAY : SLVERR, $sformatf("ovf%0d", i));
        axi_read(A_STAT, 32'h00001001, OKAY, "ovf_status");
        axi_write(A_CTRL, 32'h4, OKAY, "clear");
        axi_read(A_STAT, 32'h00000002, OKAY, "clear_status");

        // split handshake: W three cycles ahead of AW, B held with bready low
        @(posedge clk); #1;
        bus.wdata = 32'h77; bus.wvalid = 1'b1; bus.bready = 1'b0;
        @(negedge clk);
        check("split_wready", 32'(bus.wready), 32'h1);
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        @(negedge clk);
        check("split_gotw_rdy", {30'h0, bus.awready, bus.wready}, 32'h2);
        @(posedge clk); @(posedge clk); #1;
        sbq.push_back('{is_rd: 1'b0, resp: OKAY, data: 32'h0, nm: "split"});
        bus.awaddr = A_TXD; bus.awvalid = 1'b1;
        @(negedge clk);
        check("split_awready", 32'(bus.awready), 32'h1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("split_bhold%0d", i), {29'h0, bus.bvalid, bus.bresp}, 32'h4);
        end
        @(posedge clk); #1;
        bus.bready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.bready = 1'b0;
        axi_read(A_STAT, 32'h00000100, OKAY, "split_status");
        axi_write(A_CTRL, 32'h4, OKAY, "clear2");

        // single frame, DIV=4, 0x41
        axi_write(A_DIV, 32'h4, OKAY, "f_div");
        axi_write(A_CTRL, 32'h1, OKAY, "f_ctrl");
        fork
            begin
                axi_write(A_TXD, 32'h41, OKAY, "f_txd");
                for (int i = 0; i < 8; i++)
                    axi_read(A_STAT, 32'h00000006, OKAY, $sformatf("f_busy%0d", i));
            end
            watch_tx({10'h0, 1'b1, 8'h41, 1'b0}, 10, 4, "frame41");
        join
        axi_read(A_STAT, 32'h00000002, OKAY, "f_done_status");

        // back-to-back frames with DIV=0 (one cycle per bit)
        axi_write(A_CTRL, 32'h0, OKAY, "b_ctrl0");
        axi_write(A_DIV, 32'h0, OKAY, "b_div");
        axi_write(A_TXD, 32'ha5, OKAY, "b_txd0");
        axi_write(A_TXD, 32'h3c, OKAY, "b_txd1");
        fork
            axi_write(A_CTRL, 32'h1, OKAY, "b_ctrl1");
            watch_tx({1'b1, 8'h3c, 1'b0, 1'b1, 8'ha5, 1'b0}, 20, 1, "b2b");
        join
        axi_read(A_STAT, 32'h00000002, OKAY, "b_status");

        // reset in the middle of the data bits
        axi_write(A_CTRL, 32'h0, OKAY, "m_ctrl0");
        axi_write(A_DIV, 32'h4, OKAY, "m_div");
        axi_write(A_TXD, 32'h00, OKAY, "m_txd");
        fork
            axi_write(A_CTRL, 32'h1, OKAY, "m_ctrl1");
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (tx !== 1'b0 && n < 60);
                if (tx !== 1'b0) timeout("mid_start");
                repeat (10) @(negedge clk);
            end
        join
        check("mid_tx_low", 32'(tx), 32'h0);
        #2 reset = 1'b0;
        #1 check("mid_tx_async", 32'(tx), 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        axi_read(A_STAT, 32'h00000002, OKAY, "mid_status");
        axi_read(A_DIV, 32'h00000364, OKAY, "mid_div");
        axi_read(A_CTRL, 32'h00000000, OKAY, "mid_ctrl");

        repeat (2) @(negedge clk);
        check("sb_drain", 32'(sbq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
